// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad entry path: scan FSM states,
// key codes and the row/column to key code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  localparam logic [3:0] KEY_CLR  = 4'hE;
  localparam logic [3:0] KEY_ENT  = 4'hF;
  localparam logic [3:0] KEY_NONE = 4'hA;

  // Physical layout: rows top to bottom, columns left to right; column 3 (A-D) carries no function.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_NONE;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = KEY_CLR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_ENT;
      default:  code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Lowest-numbered active-low row wins when several rows are pulled together.
  function automatic logic [1:0] first_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner for a 4x4 matrix keypad: row synchronizer, column driver,
// press/release debounce FSM. Emits one key_evt per debounced press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]         row_meta;
  logic [3:0]         srow;
  scan_state_e        state, state_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic [DEB_W-1:0]   deb_cnt, deb_nxt;
  logic [1:0]         col_idx, col_nxt;
  logic [1:0]         lrow, lrow_nxt;
  logic               evt_nxt;
  logic [3:0]         code_nxt;
  logic               row_low;
  logic               any_low;

  // Rows idle high, so the synchronizer resets to all-released.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      row_meta <= 4'hF;
      srow     <= 4'hF;
    end else begin
      row_meta <= key_row;
      srow     <= row_meta;
    end
  end

  assign row_low = ~srow[lrow];
  assign any_low = ~&srow;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= ST_SCAN;
      dwell    <= '0;
      deb_cnt  <= '0;
      col_idx  <= 2'd0;
      key_col  <= 4'b1110;
      lrow     <= 2'd0;
      key_evt  <= 1'b0;
      key_code <= KEY_NONE;
    end else begin
      state    <= state_nxt;
      dwell    <= dwell_nxt;
      deb_cnt  <= deb_nxt;
      col_idx  <= col_nxt;
      key_col  <= ~(4'b0001 << col_nxt);
      lrow     <= lrow_nxt;
      key_evt  <= evt_nxt;
      key_code <= code_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    deb_nxt   = deb_cnt;
    col_nxt   = col_idx;
    lrow_nxt  = lrow;
    evt_nxt   = 1'b0;
    code_nxt  = key_code;
    case (state)
      ST_SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (any_low) begin
            lrow_nxt  = first_low_row(srow);
            deb_nxt   = '0;
            state_nxt = ST_DEBOUNCE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        // A bounce back high resumes scanning on the same column with a fresh dwell.
        if (row_low) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt = ST_HELD;
            evt_nxt   = 1'b1;
            code_nxt  = key_map(lrow, col_idx);
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end else begin
          state_nxt = ST_SCAN;
          dwell_nxt = '0;
        end
      end
      ST_HELD: begin
        if (!row_low) begin
          state_nxt = ST_RELEASE;
          deb_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        if (row_low) begin
          deb_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = ST_SCAN;
          dwell_nxt = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

endmodule

// File: rtl/keypad_entry.sv
// Decimal entry from a 4x4 keypad: up to three digits accumulated into an
// 8-bit saturating value, committed with ENTER as a one-cycle valid pulse.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [7:0] entry,
  output logic [1:0] digit_cnt,
  output logic       overflow,
  output logic [7:0] value,
  output logic       value_valid
);

  logic       key_evt;
  logic [3:0] key_code;
  logic [9:0] next_entry;

  keypad_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_scan (
    .clk     (clk),
    .rstb    (rstb),
    .key_row (key_row),
    .key_col (key_col),
    .key_evt (key_evt),
    .key_code(key_code)
  );

  // With at most two digits accumulated entry is <= 99, so ten bits always hold x*10+d.
  assign next_entry = ({2'b00, entry} << 3) + ({2'b00, entry} << 1) + {6'd0, key_code};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      entry       <= 8'd0;
      digit_cnt   <= 2'd0;
      overflow    <= 1'b0;
      value       <= 8'd0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (key_evt) begin
        if (is_digit(key_code)) begin
          if (digit_cnt != 2'd3) begin
            if (next_entry > 10'd255) begin
              entry    <= 8'hFF;
              overflow <= 1'b1;
            end else begin
              entry <= next_entry[7:0];
            end
            digit_cnt <= digit_cnt + 2'd1;
          end
        end else if (key_code == KEY_CLR) begin
          entry     <= 8'd0;
          digit_cnt <= 2'd0;
          overflow  <= 1'b0;
        end else if (key_code == KEY_ENT) begin
          value       <= entry;
          value_valid <= 1'b1;
          entry       <= 8'd0;
          digit_cnt   <= 2'd0;
          overflow    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a matrix keypad model and a
// scoreboard queue of expected committed values.
module tb_keypad_entry;

  logic       clk;
  logic       rstb;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [7:0] entry;
  logic [1:0] digit_cnt;
  logic       overflow;
  logic [7:0] value;
  logic       value_valid;

  int n_cmp = 0;
  int n_err = 0;
  int evt_cnt = 0;
  int vv_cnt = 0;
  logic [7:0] exp_q[$];

  // Keypad model: a pressed key pulls its row low only while its column is driven low.
  logic       p_en, p2_en;
  logic [1:0] p_row, p_col, p2_row, p2_col;

  keypad_entry #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .key_row    (key_row),
    .key_col    (key_col),
    .entry      (entry),
    .digit_cnt  (digit_cnt),
    .overflow   (overflow),
    .value      (value),
    .value_valid(value_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    key_row = 4'hF;
    if (p_en && !key_col[p_col]) key_row[p_row] = 1'b0;
    if (p2_en && !key_col[p2_col]) key_row[p2_row] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dut.u_scan.key_evt === 1'b1) evt_cnt++;
    if (value_valid === 1'b1) begin
      vv_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 32'(value), 32'hFFFF);
      end else begin
        check("commit_value", 32'(value), 32'(exp_q.pop_front()));
      end
    end
  end

  // Press a key, wait for its debounced event, hold, then optionally release and let release debounce run.
  task automatic press_key(input string tag, input logic [1:0] r, input logic [1:0] c,
                           input int hold, input bit do_release);
    bit got;
    got = 1'b0;
    @(negedge clk);
    p_row = r;
    p_col = c;
    p_en  = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (dut.u_scan.key_evt === 1'b1) got = 1'b1;
    end
    if (!got) check({tag, "_evt_timeout"}, 32'(got), 32'd1);
    repeat (2 + hold) @(negedge clk);
    if (do_release) begin
      p_en = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic check_acc(input string tag, input logic [7:0] e, input logic [1:0] d,
                           input logic o);
    check({tag, "_entry"}, 32'(entry), 32'(e));
    check({tag, "_digits"}, 32'(digit_cnt), 32'(d));
    check({tag, "_ovf"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    logic [3:0] col_seq [0:3];
    int ev0, vv0;
    col_seq[0] = 4'b1110;
    col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111;
    p_en = 1'b0; p2_en = 1'b0;
    p_row = 2'd0; p_col = 2'd0; p2_row = 2'd0; p2_col = 2'd0;
    rstb = 1'b0;

    // Reset state and free-running column scan.
    repeat (3) @(negedge clk);
    check_acc("rst", 8'd0, 2'd0, 1'b0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_valid", 32'(value_valid), 32'd0);
    rstb = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("scan_col_%0d", i), 32'(key_col), 32'(col_seq[(i / 4) % 4]));
      @(negedge clk);
    end

    // Basic entry 1, 2, 7, #.
    press_key("k1", 2'd0, 2'd0, 0, 1'b1);
    check_acc("k1", 8'd1, 2'd1, 1'b0);
    press_key("k2", 2'd0, 2'd1, 0, 1'b1);
    check_acc("k2", 8'd12, 2'd2, 1'b0);
    press_key("k7", 2'd2, 2'd0, 0, 1'b1);
    check_acc("k7", 8'd127, 2'd3, 1'b0);
    vv0 = vv_cnt;
    exp_q.push_back(8'd127);
    press_key("ent127", 2'd3, 2'd2, 0, 1'b1);
    check("ent127_pulses", 32'(vv_cnt - vv0), 32'd1);
    check_acc("ent127", 8'd0, 2'd0, 1'b0);

    // Saturation, digit limit, clear.
    press_key("s9a", 2'd2, 2'd2, 0, 1'b1);
    press_key("s9b", 2'd2, 2'd2, 0, 1'b1);
    check_acc("s99", 8'd99, 2'd2, 1'b0);
    press_key("s9c", 2'd2, 2'd2, 0, 1'b1);
    check_acc("s999", 8'd255, 2'd3, 1'b1);
    press_key("s5", 2'd1, 2'd1, 0, 1'b1);
    check_acc("s5_ignored", 8'd255, 2'd3, 1'b1);
    press_key("clr", 2'd3, 2'd0, 0, 1'b1);
    check_acc("clr", 8'd0, 2'd0, 1'b0);

    // Bounce: two short pulses on key 1 with its column active.
    ev0 = evt_cnt;
    for (int i = 0; i < 50 && key_col !== 4'b1110; i++) @(negedge clk);
    p_row = 2'd0; p_col = 2'd0;
    p_en = 1'b1; repeat (2) @(negedge clk);
    p_en = 1'b0; @(negedge clk);
    p_en = 1'b1; repeat (2) @(negedge clk);
    p_en = 1'b0; repeat (30) @(negedge clk);
    check("bounce_evts", 32'(evt_cnt - ev0), 32'd0);
    check_acc("bounce", 8'd0, 2'd0, 1'b0);

    ev0 = evt_cnt;
    press_key("hold4", 2'd0, 2'd0, 4, 1'b1);
    check("hold4_evts", 32'(evt_cnt - ev0), 32'd1);
    ev0 = evt_cnt;
    press_key("hold1000", 2'd0, 2'd1, 1000, 1'b1);
    check("hold1000_evts", 32'(evt_cnt - ev0), 32'd1);
    check_acc("hold1000", 8'd12, 2'd2, 1'b0);
    press_key("clr2", 2'd3, 2'd0, 0, 1'b1);

    // Keys 4 and 7 together, then ignored key A.
    p2_row = 2'd2; p2_col = 2'd0; p2_en = 1'b1;
    press_key("k4k7", 2'd1, 2'd0, 0, 1'b0);
    p2_en = 1'b0; p_en = 1'b0;
    repeat (20) @(negedge clk);
    check_acc("k4k7", 8'd4, 2'd1, 1'b0);
    vv0 = vv_cnt;
    press_key("kA", 2'd0, 2'd3, 0, 1'b1);
    check_acc("kA", 8'd4, 2'd1, 1'b0);
    check("kA_value", 32'(value), 32'd127);
    check("kA_pulses", 32'(vv_cnt - vv0), 32'd0);

    // Reset while key 2 is held after 1 has been entered.
    press_key("clr3", 2'd3, 2'd0, 0, 1'b1);
    press_key("r1", 2'd0, 2'd0, 0, 1'b1);
    press_key("r2", 2'd0, 2'd1, 0, 1'b0);
    check("r2_held_state", 32'(dut.u_scan.state), 32'd2);
    check_acc("r12", 8'd12, 2'd2, 1'b0);
    rstb = 1'b0;
    #1;
    check_acc("midrst", 8'd0, 2'd0, 1'b0);
    check("midrst_col", 32'(key_col), 32'(4'b1110));
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_valid", 32'(value_valid), 32'd0);
    @(negedge clk);
    ev0 = evt_cnt;
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_early_evt", 32'(evt_cnt - ev0), 32'd0);
    for (int i = 0; i < 200 && evt_cnt == ev0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("midrst_evts", 32'(evt_cnt - ev0), 32'd1);
    check_acc("midrst_k2", 8'd2, 2'd1, 1'b0);
    p_en = 1'b0;
    repeat (20) @(negedge clk);

    // Commit 2, then ENTER with no digits commits 0.
    exp_q.push_back(8'd2);
    press_key("ent2", 2'd3, 2'd2, 0, 1'b1);
    check("ent2_value", 32'(value), 32'd2);
    exp_q.push_back(8'd0);
    press_key("ent0", 2'd3, 2'd2, 0, 1'b1);
    check("ent0_value", 32'(value), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Decimal number entry from a 4x4 matrix keypad, the input-side counterpart of the 7-segment display path. Scans keypad columns, synchronizes and debounces the row lines, decodes keys, and accumulates up to three decimal digits into an 8-bit binary value. The live accumulator feeds the display path for preview. A committed value is presented with a one-cycle valid pulse for downstream logic (e.g. the convolution operand).

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays active. Minimum 4.
- `DEBOUNCE_CNT`, default 20000: consecutive stable cycles required for press and for release. Minimum 2.
- `clk`, input, 1: system clock.
- `rstb`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `key_row`, input, 4: keypad rows, active-low, asynchronous to `clk`.
- `key_col`, output, 4: column drive. Active-low, exactly one column low at any time.
- `entry`, output, 8: live accumulator, binary 0–255.
- `digit_cnt`, output, 2: digits entered so far, 0–3.
- `overflow`, output, 1: accumulator has saturated at 255 since the last clear or enter.
- `value`, output, 8: last committed value, held until the next enter.
- `value_valid`, output, 1: one-cycle pulse when `value` updates.

## Operation
- **Reset values:** `key_col`=4'b1110, `entry`=0, `digit_cnt`=0, `overflow`=0, `value`=0, `value_valid`=0, FSM in SCAN, synchronizer flops=4'hF.
- **Synchronizer:** `key_row` passes through a 2-flop synchronizer. All logic uses the synchronized rows `srow`.
- **Keymap** (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- **Key classes:** `*` = CLEAR, `#` = ENTER, A–D are ignored.
- **Multiple rows low:** lowest-numbered row wins.
- **FSM states:** SCAN, DEBOUNCE, HELD, RELEASE.
  - **SCAN:** a dwell counter counts 0..SCAN_DIV-1. At terminal count, if any `srow` bit is low, latch {row, col} and go to DEBOUNCE. Otherwise rotate `key_col` to the next column (col 3 wraps to col 0).
  - **DEBOUNCE:** the column is frozen.
    - Counter increments each cycle the latched row is still low.
    - If the latched row goes high, return to SCAN and resume from the same column with the dwell counter cleared.
    - On reaching DEBOUNCE_CNT, go to HELD and emit `key_evt` for one cycle.
  - **HELD:** column stays frozen. When the latched row goes high, go to RELEASE.
  - **RELEASE:** counter counts cycles with the latched row high and resets to 0 on any low. On reaching DEBOUNCE_CNT, go to SCAN.
  - Exactly one `key_evt` is emitted per physical press, regardless of hold time.
- **Accumulator:** updates on `key_evt`.
  - **Digit d, `digit_cnt`<3:** compute `entry`*10+d in 10 bits. If the result is >255, `entry`=255 and `overflow`=1; otherwise `entry`=result. `digit_cnt`++.
  - **Digit d, `digit_cnt`=3:** ignored, no state change.
  - **CLEAR:** `entry`=0, `digit_cnt`=0, `overflow`=0.
  - **ENTER:** `value`=`entry`, pulse `value_valid`, then `entry`=0, `digit_cnt`=0, `overflow`=0. ENTER with `digit_cnt`=0 commits 0.
- **Reset mid-operation:** all state returns to reset values immediately. A key held through reset release must go through DEBOUNCE again before producing an event.

## Timing
- `key_row` edge to `srow`: 2 cycles.
- FSM enters HELD at edge N, so `key_evt` is high in cycle N.
- `entry`, `digit_cnt`, `overflow` and `value` update at edge N+1. `value_valid` is high in the cycle after edge N+1 only.
- Column rotation: `key_col` changes on the edge following the SCAN terminal-count cycle. The scan period is 4·SCAN_DIV cycles with no key pressed.
- **Press latency:** from the first `srow` low seen at terminal count to `key_evt` is DEBOUNCE_CNT+1 cycles.
- **Next-press gap:** a new press cannot register before DEBOUNCE_CNT cycles of release plus the remainder of one scan dwell.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Package `keypad_pkg`:**
  - FSM state enum.
  - 4-bit key codes 0–9, KEY_CLR=4'hE, KEY_ENT=4'hF, KEY_NONE=4'hA.
  - Keymap function from {row, col} to key code.
- **Sub-module `keypad_scan`:** synchronizer, column driver, FSM and debounce counters. Outputs `key_evt` and `key_code`.
- **Top level `keypad_entry`:** instantiates `keypad_scan` and holds the accumulator and commit logic (multiply-by-10 as (x<<3)+(x<<1)).

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, and a keypad model that pulls row r low only while the pressed key's column is driven low.

1. **Reset:** after reset, `key_col` cycles 1110→1101→1011→0111→1110 every 4 cycles; all other outputs are 0.
2. **Basic entry:** press 1, 2, 7, then `#` (each press/release debounced) → `entry` steps 1, 12, 127. `value`=127 with a one-cycle `value_valid`, then `entry`=0 and `digit_cnt`=0.
3. **Saturation and digit limit:** keys 9, 9, 9 → `entry`=255, `overflow`=1. A fourth digit 5 is ignored. `*` → `entry`=0, `overflow`=0.
4. **Bounce rejection:** row low for 2 cycles, high, then low for 2 cycles → no `key_evt`. A hold of ≥4 cycles → exactly one `key_evt`. A 1000-cycle hold still gives one event.
5. **Simultaneous keys and ignored keys:** keys 4 and 7 (same column) pressed together → digit 4 registers. Key A → no change to any output.
6. **Reset mid-press:** assert `rstb` low while in HELD with `entry`=12 → all outputs return to reset values at once. With the key still held after release, one new event follows after full debounce.
